// File: rtl/mem_map_pkg.sv
// +----------------------------------------------------------------------------+
// | mem_map_pkg: CPU memory-bus address map, TX status bits, done magic value. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package mem_map_pkg;

  localparam logic [15:0] MMIO_PAGE      = 16'hffff;
  localparam logic [19:0] CYCLE_CNT_ADDR = 20'hffff0;
  localparam logic [19:0] TX_DATA_ADDR   = 20'hffff1;
  localparam logic [19:0] TX_STATUS_ADDR = 20'hffff2;
  localparam logic [19:0] SIM_CTRL_ADDR  = 20'hfffff;

  localparam int TX_STATUS_EMPTY_BIT = 0;
  localparam int TX_STATUS_FULL_BIT  = 1;
  localparam int TX_STATUS_OVF_BIT   = 2;

  localparam logic [31:0] DONE_MAGIC_DEFAULT = 32'h0000dead;

  typedef enum logic [1:0] {
    REGION_RAM      = 2'd0,
    REGION_MMIO     = 2'd1,
    REGION_UNMAPPED = 2'd2
  } region_e;

  function automatic region_e decode_region(input logic [19:0] addr,
                                            input int unsigned mem_words);
    if ({12'd0, addr} < mem_words)      return REGION_RAM;
    else if (addr[19:4] == MMIO_PAGE)   return REGION_MMIO;
    else                                return REGION_UNMAPPED;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tx_byte_fifo.sv
// +----------------------------------------------------------------------------+
// | tx_byte_fifo: byte queue with wrapping pointers, occupancy count and drop. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tx_byte_fifo import mem_map_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_async_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head_data,
  output logic       full,
  output logic       empty,
  output logic       dropped
);

  localparam int              PTR_W       = $clog2(DEPTH);
  localparam logic [PTR_W:0]  c_DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == c_DEPTH_CNT);
  assign w_do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign w_do_push = push && (!full || w_do_pop);
  assign dropped   = push && full && !w_do_pop;
  assign head_data = empty ? 8'h00 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_bus_responder.sv
// +----------------------------------------------------------------------------+
// | mem_bus_responder: word RAM plus MMIO page (cycle counter, TX, sim ctrl).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_bus_responder import mem_map_pkg::*; #(
  parameter int          MEM_WORDS  = 65536,
  parameter int          TX_DEPTH   = 4,
  parameter logic [31:0] DONE_MAGIC = DONE_MAGIC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_async_n,
  input  logic [19:0] mem_address,
  output logic [31:0] mem_read_value,
  input  logic        mem_write_en,
  input  logic [31:0] mem_write_value,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        done,
  output logic        err_unmapped
);

  localparam int ADDR_W = $clog2(MEM_WORDS);

  logic [31:0]      r_ram [MEM_WORDS];
  logic [31:0]      r_cycle_cnt;
  logic             r_overflow;
  logic             r_done;
  logic             r_err_unmapped;

  region_e          w_region;
  logic [ADDR_W-1:0] w_ram_idx;
  logic             w_ram_we;
  logic             w_cnt_we;
  logic             w_tx_push;
  logic             w_status_we;
  logic             w_sim_we;
  logic             w_unmapped_we;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_fifo_dropped;
  logic [31:0]      w_status;

  assign w_region      = decode_region(mem_address, MEM_WORDS);
  assign w_ram_idx     = mem_address[ADDR_W-1:0];
  assign w_ram_we      = mem_write_en && (w_region == REGION_RAM);
  assign w_cnt_we      = mem_write_en && (mem_address == CYCLE_CNT_ADDR);
  assign w_tx_push     = mem_write_en && (mem_address == TX_DATA_ADDR);
  assign w_status_we   = mem_write_en && (mem_address == TX_STATUS_ADDR);
  assign w_sim_we      = mem_write_en && (mem_address == SIM_CTRL_ADDR);
  assign w_unmapped_we = mem_write_en && (w_region == REGION_UNMAPPED);

  tx_byte_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk         (clk),
    .rst_async_n (rst_async_n),
    .push        (w_tx_push),
    .push_data   (mem_write_value[7:0]),
    .pop         (tx_ready),
    .head_data   (tx_data),
    .full        (w_fifo_full),
    .empty       (w_fifo_empty),
    .dropped     (w_fifo_dropped)
  );

  assign tx_valid     = !w_fifo_empty;
  assign done         = r_done;
  assign err_unmapped = r_err_unmapped;

  // RAM deliberately has no reset so program images survive a CPU reset.
  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[w_ram_idx] <= mem_write_value;
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      r_cycle_cnt    <= '0;
      r_overflow     <= 1'b0;
      r_done         <= 1'b0;
      r_err_unmapped <= 1'b0;
    end else begin
      r_cycle_cnt    <= w_cnt_we ? mem_write_value : r_cycle_cnt + 32'd1;
      // A drop in the same cycle as a status write must not be lost.
      r_overflow     <= w_fifo_dropped || (r_overflow && !w_status_we);
      r_done         <= r_done || (w_sim_we && (mem_write_value == DONE_MAGIC));
      r_err_unmapped <= w_unmapped_we;
    end
  end

  always_comb begin
    w_status                      = '0;
    w_status[TX_STATUS_EMPTY_BIT] = w_fifo_empty;
    w_status[TX_STATUS_FULL_BIT]  = w_fifo_full;
    w_status[TX_STATUS_OVF_BIT]   = r_overflow;
  end

  always_comb begin
    mem_read_value = '0;
    case (w_region)
      REGION_RAM: mem_read_value = r_ram[w_ram_idx];
      REGION_MMIO: begin
        case (mem_address)
          CYCLE_CNT_ADDR: mem_read_value = r_cycle_cnt;
          TX_STATUS_ADDR: mem_read_value = w_status;
          SIM_CTRL_ADDR:  mem_read_value = {31'd0, r_done};
          default:        mem_read_value = '0;
        endcase
      end
      default: mem_read_value = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
// +----------------------------------------------------------------------------+
// | tb_mem_bus_responder: directed self-checking bench for mem_bus_responder.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_bus_responder;

  logic        clk = 1'b0;
  logic        rst_async_n;
  logic [19:0] mem_address;
  logic [31:0] mem_read_value;
  logic        mem_write_en;
  logic [31:0] mem_write_value;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        done;
  logic        err_unmapped;

  int checks = 0;
  int passes = 0;

  localparam logic [19:0] A_CNT  = 20'hffff0;
  localparam logic [19:0] A_TX   = 20'hffff1;
  localparam logic [19:0] A_STAT = 20'hffff2;
  localparam logic [19:0] A_SIM  = 20'hfffff;

  always #5 clk = ~clk;

  mem_bus_responder dut (
    .clk             (clk),
    .rst_async_n     (rst_async_n),
    .mem_address     (mem_address),
    .mem_read_value  (mem_read_value),
    .mem_write_en    (mem_write_en),
    .mem_write_value (mem_write_value),
    .tx_valid        (tx_valid),
    .tx_data         (tx_data),
    .tx_ready        (tx_ready),
    .done            (done),
    .err_unmapped    (err_unmapped)
  );

  task automatic bus_write(input logic [19:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_address     = a;
    mem_write_value = d;
    mem_write_en    = 1'b1;
    @(negedge clk);
    mem_write_en    = 1'b0;
  endtask

  task automatic test_reset;
    rst_async_n = 1'b0;
    @(negedge clk);
    mem_address = A_CNT;
    #1;
    checks++; if (mem_read_value !== 32'd0) $display("FAIL rst_cnt: got %h expected %h", mem_read_value, 32'd0); else passes++;
    checks++; if (tx_valid !== 1'b0) $display("FAIL rst_tx_valid: got %b expected 0", tx_valid); else passes++;
    checks++; if (tx_data !== 8'h00) $display("FAIL rst_tx_data: got %h expected 00", tx_data); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b expected 0", done); else passes++;
    checks++; if (err_unmapped !== 1'b0) $display("FAIL rst_err: got %b expected 0", err_unmapped); else passes++;
    @(negedge clk);
    rst_async_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (mem_read_value !== 32'd10) $display("FAIL cnt_after_10: got %h expected %h", mem_read_value, 32'd10); else passes++;
    mem_address = A_SIM;
    #1;
    checks++; if (mem_read_value !== 32'd0) $display("FAIL sim_ctrl_rst: got %h expected 0", mem_read_value); else passes++;
    mem_address = A_STAT;
    #1;
    checks++; if (mem_read_value !== 32'd1) $display("FAIL status_rst: got %h expected 1", mem_read_value); else passes++;
  endtask

  task automatic test_ram;
    bus_write(20'h0000a, 32'h12345678);
    mem_address = 20'h0000a;
    #1;
    checks++; if (mem_read_value !== 32'h12345678) $display("FAIL ram_rw: got %h expected 12345678", mem_read_value); else passes++;
    rst_async_n = 1'b0;
    mem_address = A_CNT;
    #1;
    checks++; if (mem_read_value !== 32'd0) $display("FAIL cnt_async_rst: got %h expected 0", mem_read_value); else passes++;
    rst_async_n = 1'b1;
    mem_address = 20'h0000a;
    #1;
    checks++; if (mem_read_value !== 32'h12345678) $display("FAIL ram_survives_rst: got %h expected 12345678", mem_read_value); else passes++;
  endtask

  task automatic test_back_to_back;
    logic [19:0] addrs [3];
    logic [31:0] datas [3];
    addrs = '{20'h00001, 20'h00002, 20'h0ffff};
    datas = '{32'h11110001, 32'h22220002, 32'hffff0000};
    @(negedge clk);
    mem_write_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_address     = addrs[i];
      mem_write_value = datas[i];
      @(negedge clk);
    end
    mem_write_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_address = addrs[i];
      #1;
      checks++; if (mem_read_value !== datas[i]) $display("FAIL b2b_ram[%0d]: got %h expected %h", i, mem_read_value, datas[i]); else passes++;
    end
    mem_address = 20'h10000;
    #1;
    checks++; if (mem_read_value !== 32'd0) $display("FAIL ram_boundary_read: got %h expected 0", mem_read_value); else passes++;
  endtask

  task automatic test_tx_fill_drain;
    logic [7:0] exp [4];
    exp = '{8'h41, 8'h42, 8'h43, 8'h44};
    tx_ready = 1'b0;
    @(negedge clk);
    mem_address     = A_TX;
    mem_write_value = 32'h41;
    mem_write_en    = 1'b1;
    #1;
    checks++; if (tx_valid !== 1'b0) $display("FAIL tx_no_bypass: got %b expected 0", tx_valid); else passes++;
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk);
      mem_write_value = 32'h40 + i;
    end
    @(negedge clk);
    mem_write_en = 1'b0;
    mem_address  = A_STAT;
    #1;
    checks++; if (mem_read_value !== 32'd6) $display("FAIL tx_status_full_ovf: got %h expected 6", mem_read_value); else passes++;
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) $display("FAIL tx_head_41: got %b/%h expected 1/41", tx_valid, tx_data); else passes++;
    @(negedge clk);
    #1;
    checks++; if (tx_data !== 8'h41) $display("FAIL tx_head_stable: got %h expected 41", tx_data); else passes++;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== exp[i]) $display("FAIL tx_drain[%0d]: got %b/%h expected 1/%h", i, tx_valid, tx_data, exp[i]); else passes++;
      @(negedge clk);
      #1;
    end
    checks++; if (tx_valid !== 1'b0) $display("FAIL tx_empty_after_drain: got %b expected 0", tx_valid); else passes++;
    checks++; if (mem_read_value !== 32'd5) $display("FAIL tx_status_empty_ovf: got %h expected 5", mem_read_value); else passes++;
    tx_ready = 1'b0;
    bus_write(A_STAT, 32'h0);
    #1;
    checks++; if (mem_read_value !== 32'd1) $display("FAIL tx_ovf_clear: got %h expected 1", mem_read_value); else passes++;
  endtask

  task automatic test_full_push_pop;
    logic [7:0] exp [4];
    exp = '{8'ha1, 8'ha2, 8'ha3, 8'h55};
    tx_ready = 1'b0;
    @(negedge clk);
    mem_address  = A_TX;
    mem_write_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_write_value = 32'ha0 + i;
      @(negedge clk);
    end
    mem_write_value = 32'h55;
    tx_ready        = 1'b1;
    @(negedge clk);
    mem_write_en = 1'b0;
    tx_ready     = 1'b0;
    mem_address  = A_STAT;
    #1;
    checks++; if (mem_read_value !== 32'd2) $display("FAIL full_pushpop_status: got %h expected 2", mem_read_value); else passes++;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== exp[i]) $display("FAIL pushpop_drain[%0d]: got %b/%h expected 1/%h", i, tx_valid, tx_data, exp[i]); else passes++;
      @(negedge clk);
      #1;
    end
    checks++; if (mem_read_value !== 32'd1) $display("FAIL pushpop_status_end: got %h expected 1", mem_read_value); else passes++;
    tx_ready = 1'b0;
  endtask

  task automatic test_counter;
    bus_write(A_CNT, 32'hffffffff);
    #1;
    checks++; if (mem_read_value !== 32'hffffffff) $display("FAIL cnt_load: got %h expected ffffffff", mem_read_value); else passes++;
    @(posedge clk);
    #1;
    checks++; if (mem_read_value !== 32'd0) $display("FAIL cnt_wrap: got %h expected 0", mem_read_value); else passes++;
    @(posedge clk);
    #1;
    checks++; if (mem_read_value !== 32'd1) $display("FAIL cnt_after_wrap: got %h expected 1", mem_read_value); else passes++;
    bus_write(A_CNT, 32'h00000100);
    #1;
    checks++; if (mem_read_value !== 32'h100) $display("FAIL cnt_load_100: got %h expected 100", mem_read_value); else passes++;
  endtask

  task automatic test_sim_ctrl;
    bus_write(A_SIM, 32'h0000beef);
    #1;
    checks++; if (done !== 1'b0 || mem_read_value !== 32'd0) $display("FAIL done_wrong_magic: got %b/%h expected 0/0", done, mem_read_value); else passes++;
    @(negedge clk);
    mem_write_value = 32'h0000dead;
    mem_write_en    = 1'b1;
    #1;
    checks++; if (done !== 1'b0) $display("FAIL done_early: got %b expected 0", done); else passes++;
    @(negedge clk);
    mem_write_en = 1'b0;
    #1;
    checks++; if (done !== 1'b1 || mem_read_value !== 32'd1) $display("FAIL done_set: got %b/%h expected 1/1", done, mem_read_value); else passes++;
    bus_write(A_SIM, 32'h0);
    bus_write(A_SIM, 32'h0000beef);
    #1;
    checks++; if (done !== 1'b1) $display("FAIL done_sticky: got %b expected 1", done); else passes++;
  endtask

  task automatic test_reset_midop;
    bus_write(A_TX, 32'h77);
    #1;
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h77) $display("FAIL midop_push: got %b/%h expected 1/77", tx_valid, tx_data); else passes++;
    rst_async_n = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00 || done !== 1'b0) $display("FAIL midop_reset: got %b/%h/%b expected 0/00/0", tx_valid, tx_data, done); else passes++;
    rst_async_n = 1'b1;
  endtask

  task automatic test_unmapped;
    bus_write(20'h00000, 32'hcafef00d);
    @(negedge clk);
    mem_address     = 20'h20000;
    mem_write_value = 32'h11111111;
    mem_write_en    = 1'b1;
    #1;
    checks++; if (err_unmapped !== 1'b0) $display("FAIL err_early: got %b expected 0", err_unmapped); else passes++;
    @(negedge clk);
    mem_write_en = 1'b0;
    #1;
    checks++; if (err_unmapped !== 1'b1) $display("FAIL err_pulse: got %b expected 1", err_unmapped); else passes++;
    checks++; if (mem_read_value !== 32'd0) $display("FAIL unmapped_read: got %h expected 0", mem_read_value); else passes++;
    @(negedge clk);
    #1;
    checks++; if (err_unmapped !== 1'b0) $display("FAIL err_one_cycle: got %b expected 0", err_unmapped); else passes++;
    mem_address = 20'h00000;
    #1;
    checks++; if (mem_read_value !== 32'hcafef00d) $display("FAIL ram0_intact: got %h expected cafef00d", mem_read_value); else passes++;
    bus_write(20'hffff3, 32'h5);
    #1;
    checks++; if (err_unmapped !== 1'b0) $display("FAIL mmio_hole_no_err: got %b expected 0", err_unmapped); else passes++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_async_n     = 1'b0;
    mem_address     = '0;
    mem_write_en    = 1'b0;
    mem_write_value = '0;
    tx_ready        = 1'b0;
    test_reset();
    test_ram();
    test_back_to_back();
    test_tx_fill_drain();
    test_full_push_pop();
    test_counter();
    test_sim_ctrl();
    test_reset_midop();
    test_unmapped();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
